id_ex_stage: RTL and testbench

- ID/EX pipeline register of the five-stage RV32I core, directly downstream of the decode-stage control unit.
- Latches the control word (ruWr, immSrc, aluASrc, aluBSrc, brOp, aluOp, dmWr, dmCtrl, ruDataWrSrc) and the decoded operands into the EX stage.
- Detects load-use hazards, stalls IF/ID, inserts bubbles, and squashes on a taken branch or jump resolved in EX.

---
 rtl/core_pkg.sv | 28 ++
 rtl/id_ex_hazard.sv | 30 +++
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I pipeline: the decode control word
// and the write-back source encodings used by the hazard logic.
package core_pkg;

    typedef struct packed {
        logic       ru_wr;
        logic [2:0] imm_src;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [4:0] br_op;
        logic [3:0] alu_op;
        logic       dm_wr;
        logic [2:0] dm_ctrl;
        logic [1:0] ru_data_wr_src;
    } ctrl_t;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_PC4  = 2'b10;
    localparam logic [4:0] BR_NONE     = 5'b00000;
    localparam ctrl_t      CTRL_BUBBLE = '0;

    // Instruction writes the register file with data that only exists after MEM.
    function automatic logic is_load_wb(input ctrl_t c);
        return c.ru_wr && (c.ru_data_wr_src == WB_SRC_MEM);
    endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detection and IF/ID stall request; purely combinational.
module id_ex_hazard
    import core_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       ex_valid,
    input  ctrl_t      ex_ctrl,
    input  logic [4:0] ex_rd,
    input  logic       ex_flush,
    input  logic       ex_hold,
    output logic       hz,
    output logic       id_stall
);

    logic src_match;

    always_comb begin
        src_match = (id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd));
        // x0 is never really written, so a load targeting it cannot create a dependency
        hz        = id_valid && ex_valid && is_load_wb(ex_ctrl) &&
                    (ex_rd != 5'd0) && src_match;
        id_stall  = (hz || ex_hold) && !ex_flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX-branch squash.
// Build option: define ID_EX_PERF_CNT_EN to add saturating stall/flush counters.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
`ifdef ID_EX_PERF_CNT_EN
    , parameter int PERF_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_ruWr,
    input  logic [2:0]      id_immSrc,
    input  logic            id_aluASrc,
    input  logic            id_aluBSrc,
    input  logic [4:0]      id_brOp,
    input  logic [3:0]      id_aluOp,
    input  logic            id_dmWr,
    input  logic [2:0]      id_dmCtrl,
    input  logic [1:0]      id_ruDataWrSrc,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic            ex_flush,
    input  logic            ex_hold,
    output logic            id_stall,
    output logic            ex_valid,
    output logic            ex_ruWr,
    output logic [2:0]      ex_immSrc,
    output logic            ex_aluASrc,
    output logic            ex_aluBSrc,
    output logic [4:0]      ex_brOp,
    output logic [3:0]      ex_aluOp,
    output logic            ex_dmWr,
    output logic [2:0]      ex_dmCtrl,
    output logic [1:0]      ex_ruDataWrSrc,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd
`ifdef ID_EX_PERF_CNT_EN
    , output logic [PERF_W-1:0] perf_stall_cnt
    , output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    ctrl_t           ctrl_q, ctrl_d, id_ctrl;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [4:0]      rd_q, rd_d;
    logic            hz;

    id_ex_hazard u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_valid    (valid_q),
        .ex_ctrl     (ctrl_q),
        .ex_rd       (rd_q),
        .ex_flush    (ex_flush),
        .ex_hold     (ex_hold),
        .hz          (hz),
        .id_stall    (id_stall)
    );

    // An empty ID slot must never write the register file or memory downstream.
    always_comb begin
        id_ctrl                = '0;
        id_ctrl.ru_wr          = id_ruWr && id_valid;
        id_ctrl.imm_src        = id_immSrc;
        id_ctrl.alu_a_src      = id_aluASrc;
        id_ctrl.alu_b_src      = id_aluBSrc;
        id_ctrl.br_op          = id_brOp;
        id_ctrl.alu_op         = id_aluOp;
        id_ctrl.dm_wr          = id_dmWr && id_valid;
        id_ctrl.dm_ctrl        = id_dmCtrl;
        id_ctrl.ru_data_wr_src = id_ruDataWrSrc;
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        if (ex_flush || (!ex_hold && hz)) begin
            ctrl_d     = CTRL_BUBBLE;
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
        end else if (!ex_hold) begin
            ctrl_d     = id_ctrl;
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= CTRL_BUBBLE;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_ruWr        = ctrl_q.ru_wr;
    assign ex_immSrc      = ctrl_q.imm_src;
    assign ex_aluASrc     = ctrl_q.alu_a_src;
    assign ex_aluBSrc     = ctrl_q.alu_b_src;
    assign ex_brOp        = ctrl_q.br_op;
    assign ex_aluOp       = ctrl_q.alu_op;
    assign ex_dmWr        = ctrl_q.dm_wr;
    assign ex_dmCtrl      = ctrl_q.dm_ctrl;
    assign ex_ruDataWrSrc = ctrl_q.ru_data_wr_src;
    assign ex_pc          = pc_q;
    assign ex_rs1_data    = rs1_data_q;
    assign ex_rs2_data    = rs2_data_q;
    assign ex_imm         = imm_q;
    assign ex_rs1         = rs1_q;
    assign ex_rs2         = rs2_q;
    assign ex_rd          = rd_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    // Stall count includes cycles where a hold keeps a hazard pending.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz && !ex_flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ex_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/hold/reset cases
// plus randomized traffic against a behavioural model of the EX register.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic            ru_wr;
        logic [2:0]      imm_src;
        logic            a_src;
        logic            b_src;
        logic [4:0]      br_op;
        logic [3:0]      alu_op;
        logic            dm_wr;
        logic [2:0]      dm_ctrl;
        logic [1:0]      wb_src;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid, id_ruWr, id_aluASrc, id_aluBSrc, id_dmWr;
    logic [2:0]      id_immSrc, id_dmCtrl;
    logic [4:0]      id_brOp, id_rs1, id_rs2, id_rd;
    logic [3:0]      id_aluOp;
    logic [1:0]      id_ruDataWrSrc;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic            id_rs1_used, id_rs2_used, ex_flush, ex_hold;
    logic            id_stall, ex_valid, ex_ruWr, ex_aluASrc, ex_aluBSrc, ex_dmWr;
    logic [2:0]      ex_immSrc, ex_dmCtrl;
    logic [4:0]      ex_brOp, ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_aluOp;
    logic [1:0]      ex_ruDataWrSrc;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0]     perf_stall_cnt, perf_flush_cnt;
    int              m_stall_cnt, m_flush_cnt;
`endif

    ex_t m;
    int  n_checks = 0;
    int  n_fail = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ruWr(id_ruWr),
        .id_immSrc(id_immSrc), .id_aluASrc(id_aluASrc), .id_aluBSrc(id_aluBSrc),
        .id_brOp(id_brOp), .id_aluOp(id_aluOp), .id_dmWr(id_dmWr), .id_dmCtrl(id_dmCtrl),
        .id_ruDataWrSrc(id_ruDataWrSrc), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_flush(ex_flush), .ex_hold(ex_hold), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_ruWr(ex_ruWr), .ex_immSrc(ex_immSrc), .ex_aluASrc(ex_aluASrc),
        .ex_aluBSrc(ex_aluBSrc), .ex_brOp(ex_brOp), .ex_aluOp(ex_aluOp), .ex_dmWr(ex_dmWr),
        .ex_dmCtrl(ex_dmCtrl), .ex_ruDataWrSrc(ex_ruDataWrSrc), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic ex_t ex_bus();
        return {ex_valid, ex_ruWr, ex_immSrc, ex_aluASrc, ex_aluBSrc, ex_brOp, ex_aluOp,
                ex_dmWr, ex_dmCtrl, ex_ruDataWrSrc, ex_pc, ex_rs1_data, ex_rs2_data,
                ex_imm, ex_rs1, ex_rs2, ex_rd};
    endfunction

    // What the stage should hold after capturing the current ID inputs.
    function automatic ex_t id_word();
        ex_t w;
        w.valid = id_valid;
        w.ru_wr = id_valid ? id_ruWr : 1'b0;
        w.imm_src = id_immSrc;
        w.a_src = id_aluASrc;
        w.b_src = id_aluBSrc;
        w.br_op = id_brOp;
        w.alu_op = id_aluOp;
        w.dm_wr = id_valid ? id_dmWr : 1'b0;
        w.dm_ctrl = id_dmCtrl;
        w.wb_src = id_ruDataWrSrc;
        w.pc = id_pc;
        w.rs1_data = id_rs1_data;
        w.rs2_data = id_rs2_data;
        w.imm = id_imm;
        w.rs1 = id_rs1;
        w.rs2 = id_rs2;
        w.rd = id_rd;
        return w;
    endfunction

    function automatic logic model_hz();
        logic reads_rd;
        reads_rd = (id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd);
        return id_valid && m.valid && m.ru_wr && m.wb_src == 2'b01 && m.rd != 0 && reads_rd;
    endfunction

    function automatic logic model_stall();
        return (model_hz() || ex_hold) && !ex_flush;
    endfunction

    task automatic step();
        logic hz_now;
        ex_t  nxt;
        hz_now = model_hz();
        nxt = id_word();
        @(posedge clk);
        if (ex_flush) m = '0;
        else if (ex_hold) m = m;
        else if (hz_now) m = '0;
        else m = nxt;
`ifdef ID_EX_PERF_CNT_EN
        if (hz_now && !ex_flush && m_stall_cnt < 65535) m_stall_cnt++;
        if (ex_flush && m_flush_cnt < 65535) m_flush_cnt++;
`endif
        #1;
    endtask

    task automatic rand_id();
        id_valid = ($urandom_range(0, 3) != 0);
        id_ruWr = 1'($urandom_range(0, 1));
        id_immSrc = 3'($urandom_range(0, 7));
        id_aluASrc = 1'($urandom_range(0, 1));
        id_aluBSrc = 1'($urandom_range(0, 1));
        id_brOp = 5'($urandom_range(0, 31));
        id_aluOp = 4'($urandom_range(0, 15));
        id_dmWr = 1'($urandom_range(0, 1));
        id_dmCtrl = 3'($urandom_range(0, 7));
        id_ruDataWrSrc = 2'($urandom_range(0, 3));
        id_pc = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_rs1_used = 1'($urandom_range(0, 1));
        id_rs2_used = 1'($urandom_range(0, 1));
    endtask

    task automatic set_instr(input logic ru_wr, input logic [1:0] wb, input logic dm_wr,
                             input logic [4:0] rs1, input logic rs1u,
                             input logic [4:0] rs2, input logic rs2u, input logic [4:0] rd);
        rand_id();
        id_valid = 1'b1;
        id_ruWr = ru_wr;
        id_ruDataWrSrc = wb;
        id_dmWr = dm_wr;
        id_rs1 = rs1;
        id_rs1_used = rs1u;
        id_rs2 = rs2;
        id_rs2_used = rs2u;
        id_rd = rd;
        ex_flush = 1'b0;
        ex_hold = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m = '0;
`ifdef ID_EX_PERF_CNT_EN
        m_stall_cnt = 0;
        m_flush_cnt = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rand_id();
        ex_flush = 1'b0;
        ex_hold = 1'b0;
        rst_n = 1'b0;
        m = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ex_bus() !== ex_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", ex_bus());
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_instr(1'b1, 2'b00, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
        step();
        n_checks++;
        if (ex_bus() !== m || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_capture: got %h want %h", ex_bus(), m);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(1'b1, 2'b01, 1'b0, 5'd2, 1'b1, 5'd3, 1'b0, 5'd5);
        step();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_ruDataWrSrc !== 2'b01) begin
            n_fail++;
            $display("FAIL lu_load_in_ex: valid %b rd %0d wb %b want 1 5 01", ex_valid, ex_rd, ex_ruDataWrSrc);
        end
        set_instr(1'b1, 2'b00, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6);
        #1;
        n_checks++;
        if (id_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got %b want 1", id_stall);
        end
        step();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_ruWr !== 1'b0 || id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_bubble: valid %b ruWr %b stall %b want 0 0 0", ex_valid, ex_ruWr, id_stall);
        end
        step();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs1 !== 5'd5 || ex_bus() !== m) begin
            n_fail++;
            $display("FAIL lu_add_captured: got %h want %h", ex_bus(), m);
        end
    endtask

    task automatic test_load_x0();
        do_reset();
        set_instr(1'b1, 2'b01, 1'b0, 5'd1, 1'b1, 5'd1, 1'b0, 5'd0);
        step();
        set_instr(1'b1, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9);
        #1;
        n_checks++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_no_stall: got %b want 0", id_stall);
        end
        step();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin
            n_fail++;
            $display("FAIL x0_no_bubble: valid %b rd %0d want 1 9", ex_valid, ex_rd);
        end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        set_instr(1'b1, 2'b01, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 5'd5);
        step();
        set_instr(1'b1, 2'b00, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd4);
        id_brOp = 5'b10101;
        ex_flush = 1'b1;
        #1;
        n_checks++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_hz_stall: got %b want 0", id_stall);
        end
        step();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_ruWr !== 1'b0 || ex_dmWr !== 1'b0 || ex_brOp !== 5'd0) begin
            n_fail++;
            $display("FAIL flush_bubble: valid %b ruWr %b dmWr %b brOp %h want 0 0 0 0",
                     ex_valid, ex_ruWr, ex_dmWr, ex_brOp);
        end
        ex_hold = 1'b1;
        set_instr(1'b1, 2'b00, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
        ex_flush = 1'b1;
        ex_hold = 1'b1;
        step();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_dmWr !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_over_hold: valid %b dmWr %b want 0 0", ex_valid, ex_dmWr);
        end
        ex_flush = 1'b0;
        ex_hold = 1'b0;
    endtask

    task automatic test_hold();
        ex_t sw_word;
        do_reset();
        set_instr(1'b0, 2'b00, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd0);
        sw_word = id_word();
        step();
        for (int i = 0; i < 3; i++) begin
            rand_id();
            ex_hold = 1'b1;
            ex_flush = 1'b0;
            #1;
            n_checks++;
            if (id_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stall[%0d]: got %b want 1", i, id_stall);
            end
            step();
            n_checks++;
            if (ex_bus() !== sw_word || ex_dmWr !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_keep[%0d]: got %h want %h", i, ex_bus(), sw_word);
            end
        end
        ex_hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_instr(1'b1, 2'b01, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 5'd5);
        step();
        set_instr(1'b1, 2'b00, 1'b0, 5'd5, 1'b1, 5'd1, 1'b0, 5'd6);
        ex_hold = 1'b1;
        #2;
        rst_n = 1'b0;
        m = '0;
        #1;
        n_checks++;
        if (ex_bus() !== ex_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h want 0", ex_bus());
        end
        @(negedge clk);
        rst_n = 1'b1;
        ex_hold = 1'b0;
    endtask

    task automatic test_random();
        logic exp_stall;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_id();
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 7) == 0);
            #1;
            exp_stall = model_stall();
            n_checks++;
            if (id_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL rand_stall[%0d]: got %b want %b", i, id_stall, exp_stall);
            end
            step();
            n_checks++;
            if (ex_bus() !== m) begin
                n_fail++;
                $display("FAIL rand_ex[%0d]: got %h want %h", i, ex_bus(), m);
            end
        end
        ex_flush = 1'b0;
        ex_hold = 1'b0;
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_instr(1'b1, 2'b01, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 5'd5);
            step();
            set_instr(1'b1, 2'b00, 1'b0, 5'd5, 1'b1, 5'd1, 1'b0, 5'd6);
            step();
        end
        set_instr(1'b1, 2'b00, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 5'd6);
        ex_flush = 1'b1;
        step();
        ex_flush = 1'b0;
        n_checks++;
        if (perf_stall_cnt !== 16'd2 || perf_flush_cnt !== 16'd1 ||
            m_stall_cnt != 2 || m_flush_cnt != 1) begin
            n_fail++;
            $display("FAIL perf_counts: stall %0d flush %0d want 2 1", perf_stall_cnt, perf_flush_cnt);
        end
        set_instr(1'b1, 2'b01, 1'b0, 5'd1, 1'b0, 5'd1, 1'b0, 5'd5);
        step();
        set_instr(1'b1, 2'b00, 1'b0, 5'd5, 1'b1, 5'd1, 1'b0, 5'd6);
        ex_hold = 1'b1;
        repeat (65536 + 5) step();
        ex_hold = 1'b0;
        n_checks++;
        if (perf_stall_cnt !== 16'hFFFF || perf_flush_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL perf_saturate: stall %h flush %0d want ffff 1", perf_stall_cnt, perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        rand_id();
        ex_flush = 1'b0;
        ex_hold = 1'b0;
        m = '0;
`ifdef ID_EX_PERF_CNT_EN
        m_stall_cnt = 0;
        m_flush_cnt = 0;
`endif
        test_reset();
        test_load_use();
        test_load_x0();
        test_flush_hazard();
        test_hold();
        test_reset_mid();
        test_random();
`ifdef ID_EX_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
